// File: rtl/rx_interrupt_moderator.sv
// Receive interrupt moderator: coalesces host-write activity into interrupt requests
// by packet count or elapsed time, then holds off until the driver catches up.
module rx_interrupt_moderator #(
  parameter int PTR_W     = 64,
  parameter int NUM_PAGES = 2,
  parameter int CNT_W     = 16,
  parameter int TMR_W     = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_activity,
  input  logic [PTR_W-1:0]     hw_pointer,
  input  logic [PTR_W-1:0]     sw_pointer,
  input  logic [NUM_PAGES-1:0] huge_page_status,
  input  logic                 irq_en,
  input  logic [CNT_W-1:0]     pkt_threshold,
  input  logic [TMR_W-1:0]     timeout,
  input  logic                 interrupt_ack,
  output logic                 send_interrupt,
  output logic [CNT_W-1:0]     pending_pkts,
  output logic [31:0]          irq_total
);

  typedef enum logic [2:0] {
    WAIT_PAGE = 3'd0,
    ARMED     = 3'd1,
    COALESCE  = 3'd2,
    FIRE      = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  state_t             state_reg, state_next;
  logic [1:0]         act_pipe_reg;
  logic               act_d;
  logic [CNT_W-1:0]   pending_reg, pending_next, pending_inc, thr_eff;
  logic [TMR_W-1:0]   timer_reg, timer_next, timer_inc;
  logic [31:0]        irq_total_reg, irq_total_next;
  logic               send_reg, send_next;
  logic               ptr_match, fire_cond;

  // Activity is aligned with the host write completing two cycles later.
  assign act_d = act_pipe_reg[1];

  assign pending_inc = (act_d && (pending_reg != '1)) ? pending_reg + CNT_ONE : pending_reg;
  assign timer_inc   = (timer_reg != '1) ? timer_reg + TMR_ONE : timer_reg;
  assign thr_eff     = (pkt_threshold == '0) ? CNT_ONE : pkt_threshold;
  assign fire_cond   = (pending_inc >= thr_eff) || (timer_reg >= timeout);
  assign ptr_match   = (hw_pointer == sw_pointer);

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    timer_next     = timer_reg;
    irq_total_next = irq_total_reg;
    send_next      = 1'b0;
    case (state_reg)
      WAIT_PAGE: begin
        if (|huge_page_status) state_next = ARMED;
      end
      ARMED: begin
        if (act_d) begin
          pending_next = CNT_ONE;
          timer_next   = '0;
          state_next   = COALESCE;
        end
      end
      COALESCE: begin
        pending_next = pending_inc;
        timer_next   = timer_inc;
        if (fire_cond && irq_en) begin
          state_next = FIRE;
          send_next  = 1'b1;
        end
      end
      FIRE: begin
        pending_next = pending_inc;
        if (interrupt_ack) begin
          irq_total_next = irq_total_reg + 32'd1;
          pending_next   = act_d ? CNT_ONE : '0;
          state_next     = HOLDOFF;
        end else if (!irq_en) begin
          // Withdrawn request: counter and timer stay so it re-fires promptly.
          state_next = COALESCE;
        end else begin
          send_next = 1'b1;
        end
      end
      HOLDOFF: begin
        pending_next = pending_inc;
        if (ptr_match) begin
          timer_next = '0;
          state_next = (pending_inc != '0) ? COALESCE : ARMED;
        end
      end
      default: state_next = WAIT_PAGE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= WAIT_PAGE;
      act_pipe_reg  <= '0;
      pending_reg   <= '0;
      timer_reg     <= '0;
      irq_total_reg <= '0;
      send_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      act_pipe_reg  <= {act_pipe_reg[0], rx_activity};
      pending_reg   <= pending_next;
      timer_reg     <= timer_next;
      irq_total_reg <= irq_total_next;
      send_reg      <= send_next;
    end
  end

  assign send_interrupt = send_reg;
  assign pending_pkts   = pending_reg;
  assign irq_total      = irq_total_reg;

endmodule

// File: tb/tb_rx_interrupt_moderator.sv
// Directed bench for rx_interrupt_moderator: threshold, timeout, enable gating,
// holdoff on pointer mismatch and asynchronous reset.
module tb_rx_interrupt_moderator;

  localparam int PTR_W     = 64;
  localparam int NUM_PAGES = 2;
  localparam int CNT_W     = 16;
  localparam int TMR_W     = 20;

  logic                 clk;
  logic                 reset_n;
  logic                 rx_activity;
  logic [PTR_W-1:0]     hw_pointer;
  logic [PTR_W-1:0]     sw_pointer;
  logic [NUM_PAGES-1:0] huge_page_status;
  logic                 irq_en;
  logic [CNT_W-1:0]     pkt_threshold;
  logic [TMR_W-1:0]     timeout;
  logic                 interrupt_ack;
  logic                 send_interrupt;
  logic [CNT_W-1:0]     pending_pkts;
  logic [31:0]          irq_total;

  int tests_run    = 0;
  int tests_failed = 0;

  rx_interrupt_moderator #(
    .PTR_W(PTR_W), .NUM_PAGES(NUM_PAGES), .CNT_W(CNT_W), .TMR_W(TMR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_activity(rx_activity),
    .hw_pointer(hw_pointer),
    .sw_pointer(sw_pointer),
    .huge_page_status(huge_page_status),
    .irq_en(irq_en),
    .pkt_threshold(pkt_threshold),
    .timeout(timeout),
    .interrupt_ack(interrupt_ack),
    .send_interrupt(send_interrupt),
    .pending_pkts(pending_pkts),
    .irq_total(irq_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    rx_activity = 1'b1;
    tick();
    rx_activity = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int bad;
    reset_n          = 1'b0;
    rx_activity      = 1'b0;
    hw_pointer       = '0;
    sw_pointer       = '0;
    huge_page_status = '0;
    irq_en           = 1'b1;
    pkt_threshold    = 16'd4;
    timeout          = 20'd1000;
    interrupt_ack    = 1'b0;
    #2;
    check_eq("reset_send", 64'(send_interrupt), 64'd0);
    check_eq("reset_pending", 64'(pending_pkts), 64'd0);
    check_eq("reset_irq_total", 64'(irq_total), 64'd0);
    tick(); tick();
    reset_n = 1'b1;

    // No page granted: activity is ignored.
    pulse(); tick(); pulse();
    repeat (4) tick();
    check_eq("nopage_pending", 64'(pending_pkts), 64'd0);
    check_eq("nopage_send", 64'(send_interrupt), 64'd0);

    // Grant a page, then withdraw it: stays armed.
    huge_page_status = 2'b10;
    tick();
    huge_page_status = 2'b00;

    // Threshold of 4 with four back-to-back pulses.
    repeat (4) pulse();
    tick();
    check_eq("thr_pending_before", 64'(pending_pkts), 64'd3);
    check_eq("thr_send_before", 64'(send_interrupt), 64'd0);
    tick();
    check_eq("thr_send_rise", 64'(send_interrupt), 64'd1);
    check_eq("thr_pending_at_fire", 64'(pending_pkts), 64'd4);
    tick(); tick();
    check_eq("thr_send_held", 64'(send_interrupt), 64'd1);

    // Ack with the driver behind: enter holdoff.
    hw_pointer = 64'h40;
    sw_pointer = 64'h00;
    ack();
    check_eq("ack_send_low", 64'(send_interrupt), 64'd0);
    check_eq("ack_irq_total", 64'(irq_total), 64'd1);
    check_eq("ack_pending_clr", 64'(pending_pkts), 64'd0);

    pulse(); tick(); pulse();
    repeat (3) tick();
    check_eq("holdoff_pending", 64'(pending_pkts), 64'd2);
    repeat (5) tick();
    check_eq("holdoff_stay_pending", 64'(pending_pkts), 64'd2);
    check_eq("holdoff_stay_send", 64'(send_interrupt), 64'd0);
    sw_pointer = 64'h40;
    tick();
    check_eq("holdoff_exit_pending", 64'(pending_pkts), 64'd2);
    pulse(); pulse();
    tick();
    check_eq("resume_send_before", 64'(send_interrupt), 64'd0);
    tick();
    check_eq("resume_send_rise", 64'(send_interrupt), 64'd1);
    check_eq("resume_pending", 64'(pending_pkts), 64'd4);
    ack();
    check_eq("ack2_irq_total", 64'(irq_total), 64'd2);
    tick();
    ack();
    check_eq("stray_ack_irq_total", 64'(irq_total), 64'd2);
    check_eq("stray_ack_send", 64'(send_interrupt), 64'd0);

    // Timeout path: single packet, threshold unreachable.
    pkt_threshold = 16'd100;
    timeout       = 20'd50;
    pulse();
    cycles = 0;
    while (!send_interrupt && cycles < 100) begin
      tick();
      cycles++;
    end
    check_eq("timeout_latency", 64'(cycles), 64'd53);
    check_eq("timeout_pending", 64'(pending_pkts), 64'd1);
    ack();
    check_eq("ack3_irq_total", 64'(irq_total), 64'd3);
    tick();

    // Interrupts disabled while the threshold is met.
    pkt_threshold = 16'd2;
    timeout       = 20'd1000;
    irq_en        = 1'b0;
    pulse(); pulse();
    bad = 0;
    repeat (200) begin
      tick();
      if (send_interrupt) bad++;
    end
    check_eq("disabled_no_irq", 64'(bad), 64'd0);
    check_eq("disabled_pending", 64'(pending_pkts), 64'd2);
    irq_en = 1'b1;
    tick();
    check_eq("enable_send", 64'(send_interrupt), 64'd1);
    irq_en = 1'b0;
    tick();
    check_eq("withdraw_send", 64'(send_interrupt), 64'd0);
    irq_en = 1'b1;
    tick();
    check_eq("refire_send", 64'(send_interrupt), 64'd1);
    check_eq("refire_pending", 64'(pending_pkts), 64'd2);

    // Asynchronous reset mid-FIRE.
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_send", 64'(send_interrupt), 64'd0);
    check_eq("async_rst_pending", 64'(pending_pkts), 64'd0);
    check_eq("async_rst_irq_total", 64'(irq_total), 64'd0);
    tick();
    reset_n = 1'b1;
    pulse();
    repeat (6) tick();
    check_eq("post_rst_nopage_send", 64'(send_interrupt), 64'd0);
    check_eq("post_rst_nopage_pending", 64'(pending_pkts), 64'd0);

    // Threshold 0 behaves as 1.
    pkt_threshold    = 16'd0;
    huge_page_status = 2'b01;
    tick();
    pulse();
    tick(); tick();
    check_eq("thr0_pending", 64'(pending_pkts), 64'd1);
    check_eq("thr0_send_before", 64'(send_interrupt), 64'd0);
    tick();
    check_eq("thr0_send_rise", 64'(send_interrupt), 64'd1);
    ack();
    check_eq("thr0_irq_total", 64'(irq_total), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_interrupt_moderator.md
RX_INTERRUPT_MODERATOR -- requirements
Module: rx_interrupt_moderator

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter PTR_W, default 64, SHALL set the hw_pointer and sw_pointer width.
REQ-003 Parameter NUM_PAGES, default 2, SHALL set the number of huge-page status inputs.
REQ-004 Parameter CNT_W, default 16, SHALL set the packet counter and threshold width.
REQ-005 Parameter TMR_W, default 20, SHALL set the coalescing timer and timeout width.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 rx_activity  input  1  one-cycle pulse per packet written to host memory.
REQ-009 hw_pointer  input  PTR_W  hardware write pointer.
REQ-010 sw_pointer  input  PTR_W  driver read pointer.
REQ-011 huge_page_status  input  NUM_PAGES  per-page "buffer granted by driver" flags.
REQ-012 irq_en  input  1  host interrupt enable (level).
REQ-013 pkt_threshold  input  CNT_W  packets per interrupt; 0 is treated as 1.
REQ-014 timeout  input  TMR_W  max cycles from first pending packet to interrupt.
REQ-015 interrupt_ack  input  1  one-cycle pulse: PCIe core has issued the interrupt.
REQ-016 send_interrupt  output  1  interrupt request, level, held until acknowledged.
REQ-017 pending_pkts  output  CNT_W  packets counted since the last acknowledged interrupt.
REQ-018 irq_total  output  32  count of acknowledged interrupts.

Function
REQ-019 rx_activity SHALL pass through a 2-stage register delay (act_d); all counting SHALL use act_d.
REQ-020 The FSM SHALL have states WAIT_PAGE, ARMED, COALESCE, FIRE and HOLDOFF, and SHALL reset to WAIT_PAGE.
REQ-021 WAIT_PAGE: when any bit of huge_page_status is 1, the FSM SHALL go to ARMED on the next cycle; later deassertion of huge_page_status SHALL have no effect.
REQ-022 ARMED: act_d=1 SHALL set pending_pkts to 1, clear the timer and go to COALESCE.
REQ-023 COALESCE: the timer SHALL increment each cycle, saturating at all-ones, and act_d SHALL increment pending_pkts, saturating at all-ones.
REQ-024 COALESCE: the fire condition is (pending_pkts, including the current act_d, >= max(pkt_threshold,1)) OR (timer >= timeout).
REQ-025 COALESCE: if the fire condition holds and irq_en=1, the FSM SHALL assert send_interrupt the next cycle and go to FIRE; with irq_en=0 it SHALL stay in COALESCE, still counting.
REQ-026 FIRE: send_interrupt SHALL remain 1 until interrupt_ack; packets SHALL continue to be counted.
REQ-027 FIRE with interrupt_ack: send_interrupt SHALL be 0 the next cycle, irq_total SHALL increment (wrapping), pending_pkts SHALL clear (or load 1 if act_d that cycle), and the FSM SHALL go to HOLDOFF.
REQ-028 FIRE with irq_en=0 and no ack: send_interrupt SHALL be 0 the next cycle and the FSM SHALL return to COALESCE with the counter and timer retained; it re-fires when irq_en returns.
REQ-029 interrupt_ack outside FIRE SHALL be ignored.
REQ-030 HOLDOFF: act_d SHALL increment pending_pkts; when hw_pointer==sw_pointer, the FSM SHALL clear the timer and go to COALESCE if pending_pkts!=0, else to ARMED.
REQ-031 The pointer comparison SHALL be full PTR_W equality, with no wrap arithmetic.
REQ-032 send_interrupt SHALL be registered and never asserted outside FIRE.

Reset
REQ-033 reset_n=0 SHALL immediately (asynchronously) drive the following: send_interrupt=0, pending_pkts=0, irq_total=0, timer=0, delay stages=0, FSM=WAIT_PAGE.
REQ-034 Reset asserted mid-FIRE SHALL drop send_interrupt without waiting for ack; after release the block SHALL require huge_page_status again.

Verification
REQ-035 pkt_threshold=4, timeout=1000, irq_en=1, page granted; 4 rx_activity pulses 1 cycle apart -> send_interrupt rises 3 cycles after the 4th pulse; ack -> low the next cycle, irq_total=1.
REQ-036 pkt_threshold=100, timeout=50; a single pulse -> send_interrupt rises about 50 cycles after act_d, with pending_pkts=1.
REQ-037 irq_en=0 while the threshold is met -> no interrupt for 200 cycles; irq_en=1 -> send_interrupt the next cycle.
REQ-038 After ack, hw_pointer=0x40 and sw_pointer=0x00 with 2 pulses -> FSM stays in HOLDOFF; sw_pointer=0x40 -> COALESCE with pending_pkts=2.
REQ-039 reset_n pulsed low while send_interrupt=1 -> output 0 within the same cycle; no interrupt after release until huge_page_status is set and activity occurs.
